// File: rtl/addsub_pkg.sv
// Shared opcode encoding and default sizing for the pipelined add/sub/accumulate unit.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ACC = 2'd2,
      OP_CLR = 2'd3
   } op_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_LAT   = 2;
   localparam int DEF_ACC_W = 16;
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_stage.sv
// One elastic register slice: loads when told to advance, otherwise holds valid and payload.
module pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         adv,
   output logic         valid,
   output logic [W-1:0] data
);

   // NOTE: state uses <= so every stage samples its neighbour's pre-edge value;
   // the payload is an ordinary register, so it is reset as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (adv) begin
         valid <= in_valid;
         if (in_valid) data <= in_data;
      end
   end

endmodule

// File: rtl/pipelined_addsub_acc.sv
// Elastic LAT-stage add/sub/accumulate unit; all arithmetic and accumulator update happen at accept.
module pipelined_addsub_acc
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAT   = DEF_LAT,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_res,
   output logic             out_ovf,
   output logic [1:0]       out_op,
   output logic [CNT_W-1:0] done_cnt
);

   typedef struct packed {
      op_e              op;
      logic [ACC_W-1:0] res;
      logic             ovf;
   } stage_t;

   localparam int SW = $bits(stage_t);

   logic [LAT-1:0]   valid;
   logic [LAT-1:0]   adv;
   stage_t           stage_q [LAT];
   stage_t           s0_d;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_d;
   logic [WIDTH:0]   sum_ab;
   logic [WIDTH:0]   diff_ab;
   logic [ACC_W:0]   acc_sum;
   logic             accept;

   // Stage k moves iff some stage from k to the output is empty, or the consumer takes.
   always_comb begin
      logic tail_full;
      adv       = '0;
      tail_full = 1'b1;
      for (int k = LAT - 1; k >= 0; k--) begin
         tail_full = tail_full & valid[k];
         adv[k]    = out_ready | ~tail_full;
      end
   end

   assign in_ready = adv[0];
   assign accept   = in_valid & in_ready;

   assign sum_ab  = {1'b0, in_a} + {1'b0, in_b};
   assign diff_ab = {1'b0, in_a} - {1'b0, in_b};
   assign acc_sum = {1'b0, acc} + (ACC_W+1)'(in_a) + (ACC_W+1)'(in_b);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      s0_d    = '0;
      acc_d   = acc;
      s0_d.op = op_e'(in_op);
      case (op_e'(in_op))
         OP_ADD: begin
            s0_d.res = ACC_W'(sum_ab);
            s0_d.ovf = sum_ab[WIDTH];
         end
         OP_SUB: begin
            s0_d.res = {{(ACC_W-WIDTH-1){diff_ab[WIDTH]}}, diff_ab};
            s0_d.ovf = diff_ab[WIDTH];
         end
         OP_ACC: begin
            s0_d.res = acc_sum[ACC_W-1:0];
            s0_d.ovf = acc_sum[ACC_W];
            acc_d    = acc_sum[ACC_W-1:0];
         end
         OP_CLR: begin
            s0_d.res = acc;
            acc_d    = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         done_cnt <= '0;
      end else begin
         if (accept) acc <= acc_d;
         if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < LAT; g++) begin : g_stage
      if (g == 0) begin : g_first
         pipe_stage #(.W(SW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_data  (s0_d),
            .adv      (adv[g]),
            .valid    (valid[g]),
            .data     (stage_q[g])
         );
      end else begin : g_rest
         pipe_stage #(.W(SW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (valid[g-1]),
            .in_data  (stage_q[g-1]),
            .adv      (adv[g]),
            .valid    (valid[g]),
            .data     (stage_q[g])
         );
      end
   end

   assign out_valid = valid[LAT-1];
   assign out_res   = stage_q[LAT-1].res;
   assign out_ovf   = stage_q[LAT-1].ovf;
   assign out_op    = stage_q[LAT-1].op;

endmodule

// File: doc/pipelined_addsub_acc.md
Name: pipelined_addsub_acc

Overview:
- Parametrised successor of the team's 4-bit add task: an elastic, LAT-stage pipelined add/subtract/accumulate unit.
- Sits between a stimulus/producer and a consumer.
- Uses valid/ready handshakes on both sides and sustains one operation per clock.
- Keeps a running accumulator and a count of completed operations for scoreboard cross-checks.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- LAT, 2, pipeline depth in register stages (>=1).
- ACC_W, 16, accumulator and result width (>= WIDTH+2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer presents an operation.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  opcode: ADD=0, SUB=1, ACC=2, CLR=3.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_res  out  ACC_W  result.
- out_ovf  out  1  carry/borrow/wrap flag for out_res.
- out_op  out  2  opcode of the presented result.
- done_cnt  out  CNT_W  number of results handed off (out_valid && out_ready).

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchroniser):
  - all stage valid bits = 0, accumulator = 0, done_cnt = 0.
  - out_valid = 0, out_res = 0, out_ovf = 0, out_op = 0.
  - in_ready = 1 once rst_n is high.
- Reset mid-operation: every in-flight operation is discarded and the accumulator clears. No result is ever emitted for an operation accepted before reset.
- Accept rule: an operation is taken at a rising edge where in_valid && in_ready.
- Retire rule: a result is handed off at a rising edge where out_valid && out_ready.
- Pipeline:
  - stage k advances when it is empty or when stage k+1 advances. The last stage advances when out_ready = 1.
  - in_ready = !valid[0] || adv[0]. This is a combinational path from out_ready, and it is permitted.
- Latency: with out_ready held at 1, an op accepted at edge N gives out_valid = 1 after edge N+LAT-1 and is retired at edge N+LAT. For LAT=1, out_valid rises right after the accept edge.
- Throughput: 1 op/cycle. No bubbles are inserted. A stalled pipeline holds all stages and out_* stable until retire.
- Arithmetic, computed entirely in stage 0 at the accept edge; later stages only carry results:
  - ADD: out_res = zero-extended {carry, a+b} (WIDTH+1 bits). out_ovf = carry bit.
  - SUB: d = a-b in WIDTH+1-bit two's complement, sign-extended to ACC_W. out_ovf = 1 iff a < b (borrow).
  - ACC: acc_next = acc + a + b mod 2^ACC_W. out_res = acc_next. out_ovf = carry out of bit ACC_W-1.
  - CLR: acc_next = 0, out_res = acc value before clearing, out_ovf = 0.
  - ADD and SUB leave acc unchanged.
- Accumulator ordering: acc updates at the accept edge, so back-to-back ACC ops chain correctly independent of LAT or backpressure.
- Backpressure: in_valid with in_ready = 0 has no effect. The producer must hold its data; this unit does not check that.
- done_cnt increments once per retire and wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and retire in the same cycle, with the pipeline full, is legal and keeps occupancy constant.

Decomposition:
- Package addsub_pkg holds:
  - typedef enum logic [1:0] op_e {OP_ADD, OP_SUB, OP_ACC, OP_CLR}.
  - a packed struct stage_t {op, res[ACC_W], ovf}.
- One sub-module, pipe_stage: a single elastic register slice (valid, payload, adv in/out). It is instantiated LAT times via generate.
- The top holds the stage-0 arithmetic, accumulator and counter.

Test Plan:
- Reset then ADD a=15, b=15 with out_ready=1 -> after LAT edges: out_res=30, out_ovf=1, done_cnt=1.
- SUB a=3, b=5 (WIDTH=4) -> out_res=0xFFFE (-2 at ACC_W=16), out_ovf=1. SUB a=9, b=4 -> out_res=5, out_ovf=0.
- Four back-to-back ACC ops (1,2), (3,4), (5,6), (7,8) -> out_res sequence 3, 10, 21, 36. Then CLR -> out_res=36, and the next ACC (1,1) -> 2.
- Hold out_ready=0 while streaming 20 random ops -> in_ready drops after LAT+... exactly LAT accepts. Outputs stay stable. Releasing out_ready retires all in order with none lost, and done_cnt=20.
- Preload acc=0xFFFF via ACC ops, then ACC (1,0) -> out_res=0, out_ovf=1.
- Assert rst_n low for one cycle with LAT ops in flight -> out_valid=0 immediately. No stale results after release, and acc=0, done_cnt=0.
